// File: rtl/fifo_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// fifo_arbiter_pkg
// Shared types and width helpers for the round-robin wide-to-narrow
// serialising arbiter (fifo_arbiter_rr) and its rr_pick sub-module.
//
// Contents:
//   arbState_t  - arbiter state: ARB_IDLE (no lock) / ARB_BURST (locked)
//   cntWidth()  - width of a per-channel beat counter holding 0..BEATS
//                 (CNT_W = $clog2(BEATS+1))
//   ptrWidth()  - width of a channel index, never below one bit
//                 (PTR_W = max(1, $clog2(NUM_CH)))
// ---------------------------------------------------------------------------
package fifo_arbiter_pkg;

   typedef enum logic {
      ARB_IDLE  = 1'b0,
      ARB_BURST = 1'b1
   } arbState_t;

   // Counter width able to hold every value from 0 (empty) up to BEATS (full).
   function automatic int cntWidth(input int beats);
      return $clog2(beats + 1);
   endfunction

   // Channel index width; a single-channel build still needs a one-bit index.
   function automatic int ptrWidth(input int numCh);
      return (numCh > 1) ? $clog2(numCh) : 1;
   endfunction

endpackage

// File: rtl/fifo_arbiter_rr_pick.sv
// ---------------------------------------------------------------------------
// rr_pick
// Combinational round-robin first-pending finder. Starting at i_ptr and
// wrapping past NUM_CH-1 back to 0, returns the first channel whose
// pending bit is set.
//
// Ports:
//   i_pending  [NUM_CH-1:0]  per-channel request vector
//   i_ptr      [PTR_W-1:0]   channel with the highest priority this cycle
//   o_grant    [PTR_W-1:0]   selected channel (0 when nothing is pending)
//   o_anyValid               at least one pending bit is set
// ---------------------------------------------------------------------------
module rr_pick
   import fifo_arbiter_pkg::*;
#(
   parameter int NUM_CH = 2,
   parameter int PTR_W  = 1
)
(
   input  logic [NUM_CH-1:0] i_pending,
   input  logic [PTR_W-1:0]  i_ptr,
   output logic [PTR_W-1:0]  o_grant,
   output logic              o_anyValid
);

   // Walk the channels from farthest-from-pointer down to the pointer itself,
   // so the last hit written is the one closest to the pointer in wrap order.
   always_comb begin
      int idx;
      o_grant    = '0;
      o_anyValid = 1'b0;
      idx        = 0;
      for (int k = NUM_CH - 1; k >= 0; k--) begin
         idx = (int'(i_ptr) + k) % NUM_CH;
         if (i_pending[idx]) begin
            o_grant    = PTR_W'(idx);
            o_anyValid = 1'b1;
         end
      end
   end

endmodule

// File: rtl/fifo_arbiter_rr.sv
// ---------------------------------------------------------------------------
// fifo_arbiter_rr
// N-channel wide-to-narrow serialising arbiter feeding one downstream FIFO
// write port. Each channel owns a single-entry buffer holding one word of
// BEATS beats; words are emitted most-significant beat first, one channel
// at a time (burst lock), channels served round-robin, and the narrow port
// honours downstream backpressure.
//
// Parameters:
//   NUM_CH  number of input channels (1..8)
//   BEAT_W  width of one output beat
//   BEATS   beats per input word (2..16)
//
// Ports:
//   clk           clock, all logic on the rising edge
//   rst           synchronous active-high reset
//   wrdata_in     channel i word at [(i+1)*BEATS*BEAT_W-1 : i*BEATS*BEAT_W]
//   push_in       per-channel push strobe, one cycle per word
//   ready_out     per-channel "push accepted this cycle" (combinational)
//   wrdata_out    beat to downstream FIFO (0 when push_out is low)
//   push_out      downstream write strobe
//   out_ready     downstream can accept a beat this cycle
//   overflow_err  sticky flag: push on a channel whose ready_out was low
//
// Build option:
//   ARB_OVERFLOW_CHECK_EN  when defined, illegal pushes set overflow_err;
//                          otherwise overflow_err is tied low. Illegal pushes
//                          are dropped either way.
// ---------------------------------------------------------------------------
module fifo_arbiter_rr
   import fifo_arbiter_pkg::*;
#(
   parameter int NUM_CH = 2,
   parameter int BEAT_W = 240,
   parameter int BEATS  = 2
)
(
   input  logic                           clk,
   input  logic                           rst,
   input  logic [NUM_CH*BEATS*BEAT_W-1:0] wrdata_in,
   input  logic [NUM_CH-1:0]              push_in,
   output logic [NUM_CH-1:0]              ready_out,
   output logic [BEAT_W-1:0]              wrdata_out,
   output logic                           push_out,
   input  logic                           out_ready,
   output logic                           overflow_err
);

   localparam int WORD_W = BEATS * BEAT_W;
   localparam int CNT_W  = cntWidth(BEATS);
   localparam int PTR_W  = ptrWidth(NUM_CH);
   localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(BEATS);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

   logic [WORD_W-1:0] r_buf [NUM_CH];
   logic [CNT_W-1:0]  r_cnt [NUM_CH];
   arbState_t         r_state;
   logic [PTR_W-1:0]  r_lock;
   logic [PTR_W-1:0]  r_ptr;

   logic [NUM_CH-1:0] w_pending;
   logic [NUM_CH-1:0] w_accept;
   logic [NUM_CH-1:0] w_nextPending;
   logic [PTR_W-1:0]  w_idlePick;
   logic [PTR_W-1:0]  w_nextPick;
   logic [PTR_W-1:0]  w_grant;
   logic [PTR_W-1:0]  w_ptrNext;
   logic              w_idleAny;
   logic              w_nextAny;
   logic              w_grantValid;
   logic              w_emit;
   logic              w_lastBeat;
   logic [CNT_W-1:0]  w_grantCnt;
   logic [WORD_W-1:0] w_grantWord;
   int                w_beatIdx;

   // A channel is pending whenever its buffer still holds unsent beats.
   always_comb begin
      w_pending = '0;
      for (int i = 0; i < NUM_CH; i++) begin
         w_pending[i] = (r_cnt[i] != '0);
      end
   end

   rr_pick #(
      .NUM_CH (NUM_CH),
      .PTR_W  (PTR_W)
   ) u_idlePick (
      .i_pending  (w_pending),
      .i_ptr      (r_ptr),
      .o_grant    (w_idlePick),
      .o_anyValid (w_idleAny)
   );

   // While locked the burst owner keeps the grant; when idle the grant is the
   // combinational round-robin pick so a beat can leave in the same cycle.
   always_comb begin
      w_grant      = w_idlePick;
      w_grantValid = w_idleAny;
      if (r_state == ARB_BURST) begin
         w_grant      = r_lock;
         w_grantValid = 1'b1;
      end
   end

   // Beat emission: the remaining count selects the beat, so the MS beat goes
   // first and the LS beat last. Output data is forced to 0 when idle.
   always_comb begin
      w_grantCnt  = r_cnt[w_grant];
      w_grantWord = r_buf[w_grant];
      w_emit      = w_grantValid & (w_grantCnt != '0) & out_ready;
      w_lastBeat  = w_emit & (w_grantCnt == CNT_ONE);
      w_beatIdx   = w_emit ? (int'(w_grantCnt) - 1) : 0;
      push_out    = w_emit;
      wrdata_out  = w_emit ? w_grantWord[w_beatIdx*BEAT_W +: BEAT_W] : '0;
   end

   // A channel accepts a new word when empty, or when its final beat is
   // leaving this very cycle so the buffer refills without a gap.
   always_comb begin
      ready_out = '0;
      for (int i = 0; i < NUM_CH; i++) begin
         ready_out[i] = (r_cnt[i] == '0) |
                        (w_grantValid & (w_grant == PTR_W'(i)) &
                         (r_cnt[i] == CNT_ONE) & out_ready);
      end
      w_accept = push_in & ready_out;
   end

   // End-of-burst lookahead: pointer moves past the finishing channel and the
   // next owner is chosen from what will be pending after this edge, which
   // includes words landing this cycle, giving zero-bubble handover.
   always_comb begin
      w_ptrNext = (w_grant == PTR_W'(NUM_CH - 1)) ? '0 : (w_grant + PTR_W'(1));
      w_nextPending = '0;
      for (int i = 0; i < NUM_CH; i++) begin
         w_nextPending[i] = ((r_cnt[i] != '0) & (w_grant != PTR_W'(i))) |
                            w_accept[i];
      end
   end

   rr_pick #(
      .NUM_CH (NUM_CH),
      .PTR_W  (PTR_W)
   ) u_nextPick (
      .i_pending  (w_nextPending),
      .i_ptr      (w_ptrNext),
      .o_grant    (w_nextPick),
      .o_anyValid (w_nextAny)
   );

   // Per-channel buffers and counters. A push that lands while the last beat
   // leaves takes priority over the decrement, reloading the full count.
   // Buffer contents need no reset because a zero count hides them.
   always_ff @(posedge clk) begin
      for (int i = 0; i < NUM_CH; i++) begin
         if (rst) begin
            r_cnt[i] <= '0;
         end else if (w_accept[i]) begin
            r_cnt[i] <= CNT_FULL;
            r_buf[i] <= wrdata_in[i*WORD_W +: WORD_W];
         end else if (w_emit && (w_grant == PTR_W'(i))) begin
            r_cnt[i] <= r_cnt[i] - CNT_ONE;
         end
      end
   end

   // Arbiter FSM. Nothing moves without an emitted beat, so backpressure
   // freezes lock and pointer. Finishing a burst either hands straight over
   // to the next pending channel or drops back to idle.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= ARB_IDLE;
         r_lock  <= '0;
         r_ptr   <= '0;
      end else if (w_emit) begin
         if (w_lastBeat) begin
            r_ptr <= w_ptrNext;
            if (w_nextAny) begin
               r_state <= ARB_BURST;
               r_lock  <= w_nextPick;
            end else begin
               r_state <= ARB_IDLE;
            end
         end else begin
            r_state <= ARB_BURST;
            r_lock  <= w_grant;
         end
      end
   end

`ifdef ARB_OVERFLOW_CHECK_EN
   logic r_overflow;

   // Sticky error: any push on a channel that could not take it this cycle.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_overflow <= 1'b0;
      end else if (|(push_in & ~ready_out)) begin
         r_overflow <= 1'b1;
      end
   end

   assign overflow_err = r_overflow;
`else
   assign overflow_err = 1'b0;
`endif

endmodule
